nic: RTL
========

# nic

Network interface controller between a processing element and one mesh router's PE port. It gives the processor a 4-word register map, made of input and output channel buffers plus status words. On the network side it runs the router's `si`/`ri`/`di` handshake. Injection is gated by the router's `polarity` so each packet enters the router in the external phase of its virtual channel. One `nic` is instantiated per router in the mesh.

## Interface
- `DATA_W`, 64, packet and processor data width
- `VC_BIT`, 63, packet bit carrying the virtual-channel id
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-low
- `addr` in 2: register select (0 in-buf, 1 in-status, 2 out-buf, 3 out-status)
- `d_in` in DATA_W: processor write data
- `d_out` out DATA_W: processor read data
- `nicEn` in 1: register access enable
- `nicWrEn` in 1: 1 = write, 0 = read (qualified by `nicEn`)
- `net_si` in 1: router has a packet for the PE (router `peso`)
- `net_ri` out 1: NIC can accept a packet (router `pero`)
- `net_di` in DATA_W: packet from router (router `pedo`)
- `net_so` out 1: NIC injects a packet (router `pesi`)
- `net_ro` in 1: router can accept a packet (router `peri`)
- `net_do` out DATA_W: packet to router (router `pedi`)
- `net_polarity` in 1: router phase signal

## Operation
- State is two one-entry channels: `in_buf` with `in_full`, and `out_buf` with `out_full`.
- Receive path:
  - `net_ri = ~in_full`.
  - On an edge with `net_si && net_ri`: `in_buf <= net_di`, `in_full <= 1`.
- Send path:
  - `net_do = out_buf` at all times.
  - `net_so = out_full && net_ro && (out_buf[VC_BIT] != net_polarity)`.
  - On an edge with `net_so`: `out_full <= 0`.
- Processor write, `nicEn && nicWrEn && addr==2`:
  - If `!out_full`: `out_buf <= d_in`, `out_full <= 1`.
  - Otherwise the write is rejected (see Configuration).
  - Writes to addr 0, 1 and 3 are ignored.
- Processor read, `nicEn && !nicWrEn`, `d_out` combinational:
  - addr 0 returns `in_buf`; the same edge sets `in_full <= 0`.
  - addr 1 returns `{63'b0, in_full}`.
  - addr 2 returns `out_buf`.
  - addr 3 returns `{62'b0, ovf, out_full}`.
- `d_out = 0` when not reading.
- Reads of addr 1, 2 and 3 have no side effects.
- Boundary rules:
  - Full input buffer: `net_ri=0`. The router holds the packet; no loss.
  - Empty input buffer read at addr 0: returns the stale `in_buf`; `in_full` stays 0.
  - Read-clear and capture never occur on the same edge, because `net_ri=0` while full. `net_ri` rises the cycle after the clearing read.
  - Processor write in the same cycle as `net_so`: `out_full` is still 1 at that edge, so the write is rejected.
  - Polarity mismatch: the packet waits; `out_full` stays 1.
- Reset active on any edge: `in_full=0`, `out_full=0`, `ovf=0`, `in_buf=0`, `out_buf=0`. Any in-flight transfer is discarded.

## Timing
- Values after reset:
  - `net_ri=1`, `net_so=0`, `net_do=0`, `d_out=0`.
  - `ovf`, `in_full` and `out_full` read back as 0.
- Write to send: a write at edge N sets `out_full` for cycle N+1. `net_so` can be high in cycle N+1 at the earliest.
- Receive to status: a capture at edge N makes status read as 1 from cycle N+1.
- The read path has zero-cycle latency; the clear takes effect at the next edge.
- Throughput is one packet per 2 cycles per direction, due to the single-entry buffers.

## Configuration
- `NIC_OVF_DETECT_EN` defined:
  - A rejected addr-2 write sets sticky `ovf`.
  - `ovf` is cleared only by reset, or by a write to addr 3 with `d_in[1]=1`.
- Not defined:
  - `ovf` is tied to 0 and rejected writes are silently dropped.
  - The addr-3 write has no effect.

## Structure
- `nic_pkg` holds:
  - the `ADDR_IN_BUF`, `ADDR_IN_STAT`, `ADDR_OUT_BUF` and `ADDR_OUT_STAT` localparams;
  - `VC_BIT`;
  - the status bit indices `STAT_FULL=0` and `STAT_OVF=1`.
- Sub-module `nic_chan_buf`: a one-entry register with full flag, `wr_en`/`rd_clr`/`full`/`data` ports, instantiated twice.

## Test plan
- Reset:
  - Stimulus: hold `reset=0` for 2 cycles.
  - Response: `net_ri=1`, `net_so=0`, and reads of addr 1 and addr 3 return 0.
- Send, VC0:
  - Stimulus: write 64'h0011223344556677 to addr 2 with `net_ro=1`; `net_polarity` is 0 then 1.
  - Response: `net_so` is high only in the polarity=1 cycle with `net_do` equal to that value; addr 3 reads 0 the next cycle.
- Receive:
  - Stimulus: pulse `net_si` with `net_di`=64'hAABBCCDD11223344.
  - Response: `net_ri` drops; addr 1 reads 1; an addr-0 read returns the value; `net_ri`=1 the following cycle.
- Backpressure:
  - Stimulus: hold `net_ro=0` with a packet pending.
  - Response: `net_so=0` and `out_full` stays 1 for 10 cycles; the send happens within 2 cycles of `net_ro=1`.
- Overflow, macro on:
  - Stimulus: two writes back-to-back with `net_ro=0`.
  - Response: addr 3 reads 2'b11 and `out_buf` keeps the first value; a write of 2 to addr 3 clears `ovf`.
- Reset mid-operation:
  - Stimulus: both buffers full, assert reset.
  - Response: next cycle `net_ri=1` and `net_so=0`, and the status reads are 0.

Source files
------------

// File: rtl/nic_pkg.sv
// nic_pkg: shared register map, packet field positions and status bit
// indices for the network interface controller.
package nic_pkg;

   localparam logic [1:0] ADDR_IN_BUF   = 2'd0;
   localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
   localparam logic [1:0] ADDR_OUT_BUF  = 2'd2;
   localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

   localparam int VC_BIT = 63;

   localparam int STAT_FULL = 0;
   localparam int STAT_OVF  = 1;

endpackage

// File: rtl/nic_chan_buf.sv
// nic_chan_buf: one-entry channel buffer with a full flag. A write loads the
// data and sets full; a read-clear drops full but leaves the data in place,
// so a later read of an empty buffer still sees the last value.
module nic_chan_buf #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_clr,
   output logic         full,
   output logic [W-1:0] data
);

   // Load on write, drop the full flag on read-clear; a write wins if both occur.
   always_ff @(posedge clk) begin
      if (!reset) begin
         full <= 1'b0;
         data <= '0;
      end else if (wr_en) begin
         full <= 1'b1;
         data <= wr_data;
      end else if (rd_clr) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/nic.sv
// nic: network interface controller between a processing element and the PE
// port of one mesh router. Offers a 4-word register map to the processor and
// runs the si/ri/di handshake towards the router, gating injection on the
// router polarity so a packet enters in the external phase of its VC.
// Optional feature: define NIC_OVF_DETECT_EN to record rejected out-buffer
// writes in a sticky overflow bit (cleared by writing d_in[1]=1 to addr 3).
module nic #(
   parameter int DATA_W = 64,
   parameter int VC_BIT = nic_pkg::VC_BIT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              nicEn,
   input  logic              nicWrEn,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di,
   output logic              net_so,
   input  logic              net_ro,
   output logic [DATA_W-1:0] net_do,
   input  logic              net_polarity
);

   import nic_pkg::*;

   logic              rd_access;
   logic              wr_access;
   logic              in_full;
   logic [DATA_W-1:0] in_data;
   logic              out_full;
   logic [DATA_W-1:0] out_data;
   logic              in_capture;
   logic              in_rd_clr;
   logic              out_load;
   logic              out_reject;
   logic              ovf;

   assign rd_access = nicEn && !nicWrEn;
   assign wr_access = nicEn && nicWrEn;

   assign net_ri     = ~in_full;
   assign in_capture = net_si && net_ri;
   assign in_rd_clr  = rd_access && (addr == ADDR_IN_BUF);

   assign out_load   = wr_access && (addr == ADDR_OUT_BUF) && !out_full;
   assign out_reject = wr_access && (addr == ADDR_OUT_BUF) && out_full;

   assign net_do = out_data;
   assign net_so = out_full && net_ro && (out_data[VC_BIT] != net_polarity);

   nic_chan_buf #(.W(DATA_W)) u_in_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (in_capture),
      .wr_data (net_di),
      .rd_clr  (in_rd_clr),
      .full    (in_full),
      .data    (in_data)
   );

   nic_chan_buf #(.W(DATA_W)) u_out_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (out_load),
      .wr_data (d_in),
      .rd_clr  (net_so),
      .full    (out_full),
      .data    (out_data)
   );

`ifdef NIC_OVF_DETECT_EN
   logic ovf_q;
   logic ovf_clr;

   assign ovf_clr = wr_access && (addr == ADDR_OUT_STAT) && d_in[STAT_OVF];

   // Sticky overflow: set by a rejected out-buffer write, cleared by software.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ovf_q <= 1'b0;
      end else if (out_reject) begin
         ovf_q <= 1'b1;
      end else if (ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign ovf = ovf_q;
`else
   logic unused_reject;
   assign unused_reject = out_reject;
   assign ovf = 1'b0;
`endif

   // Zero-latency register read mux; drives zero whenever no read is in progress.
   always_comb begin
      d_out = '0;
      if (rd_access) begin
         case (addr)
            ADDR_IN_BUF:   d_out = in_data;
            ADDR_IN_STAT:  d_out[STAT_FULL] = in_full;
            ADDR_OUT_BUF:  d_out = out_data;
            ADDR_OUT_STAT: begin
               d_out[STAT_FULL] = out_full;
               d_out[STAT_OVF]  = ovf;
            end
            default:       d_out = '0;
         endcase
      end
   end

endmodule
